mgpio_ext: RTL and testbench
============================

MGPIO_EXT -- requirements
Module: mgpio_ext

Interface
REQ-001 SHALL have parameter BANKS, default 1: number of GPIO banks.
REQ-002 SHALL have parameter WIDTH, default 8: pins per bank and bus data width.
REQ-003 SHALL have parameter BANK_AS_BITS, default 12: address bits decoded inside one bank.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: input synchronizer depth.
REQ-005 SHALL have derived parameter BANKS_WIDTH = (BANKS>1 ? clog2(BANKS) : 1).
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port bus_addr, input, BANK_AS_BITS+BANKS_WIDTH: upper BANKS_WIDTH bits are the bank, lower bits are the register offset.
REQ-009 SHALL have ports bus_data_in (input, WIDTH), bus_write (input, 1), bus_data_out (output, WIDTH) and bus_err (output, 1).
REQ-010 SHALL have ports gpio_in (input), gpio_out (output) and gpio_oe (output), each BANKS*WIDTH bits; bank b owns bits [b*WIDTH +: WIDTH].
REQ-011 SHALL have ports irq_bank (output, BANKS): per-bank interrupt, and irq (output, 1): OR of irq_bank.

Function
REQ-012 SHALL implement this per-bank register map by offset: 0 DATA (rw), 1 DIR (rw, 1=output), 2 IN (ro, synchronized pins), 3 SET (wo), 4 CLR (wo), 5 TGL (wo), 6 RISE_EN (rw), 7 FALL_EN (rw), 8 STATUS (rw1c).
REQ-013 SHALL drive bus_data_out combinationally from the addressed register in the same cycle; reads of SET/CLR/TGL SHALL return 0.
REQ-014 SHALL assert bus_err combinationally when offset > 8 or bank index >= BANKS; in that case bus_data_out SHALL be 0 and a write SHALL change no state.
REQ-015 SHALL apply all writes at the clk edge on which bus_write is high; writes to IN SHALL be ignored without bus_err.
REQ-016 SHALL update DATA on SET to DATA|din, on CLR to DATA&~din, and on TGL to DATA^din.
REQ-017 SHALL drive gpio_out = DATA and gpio_oe = DIR, both registered, with no added latency beyond the register.
REQ-018 SHALL pass gpio_in through a SYNC_STAGES flop chain, and IN SHALL reflect a stable pin change exactly SYNC_STAGES cycles later.
REQ-019 SHALL keep a one-cycle-delayed copy of IN; rise = IN&~prev and fall = ~IN&prev.
REQ-020 SHALL set STATUS bit i on the edge after (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
REQ-021 SHALL clear STATUS bit i on a STATUS write with din[i]=1; a simultaneous set event on the same bit SHALL take priority, leaving the bit at 1.
REQ-022 SHALL drive irq_bank[b] = |STATUS of bank b, registered through the STATUS flops, with no extra delay.
REQ-023 SHALL not set STATUS on enable-bit changes alone; enabling RISE_EN while a pin is steadily high SHALL produce no event.
REQ-024 SHALL record a pin toggling faster than the sample rate only on sampled edges, with no event queueing; STATUS is sticky.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force DATA, DIR, RISE_EN, FALL_EN, STATUS, all synchronizer flops and the prev copy to 0.
REQ-026 SHALL therefore hold gpio_out=0, gpio_oe=0, irq_bank=0 and irq=0 in reset.
REQ-027 SHALL lose any edge in flight when reset is asserted, and SHALL not generate a spurious event on release for pins held low.

Structure
REQ-028 SHALL put register offset constants (DATA..STATUS) and the last-valid-offset constant in package mgpio_ext_pkg.
REQ-029 SHALL instantiate one sub-module mgpio_ext_bank per bank via generate; it holds registers, synchronizer, edge detect and STATUS.
REQ-030 SHALL keep address decode, bus_err and read mux in the top level.
REQ-031 SHALL target 120-400 lines of RTL in total.

Verification
REQ-032 SHALL cover: BANKS=2, WIDTH=8; write DATA=0xA5 to bank1, then SET 0x0F, CLR 0x81, TGL 0xFF -> readback 0xA5, 0xAF, 0x2E, 0xD1; gpio_out[15:8] matches after each write.
REQ-033 SHALL cover: SYNC_STAGES=2, gpio_in[0] 0->1 at cycle N -> IN bit0=1 readable at N+2, and STATUS bit0=1 at N+3 only if RISE_EN[0]=1.
REQ-034 SHALL cover: FALL_EN=0x01, pin0 falls on the same cycle STATUS is written 0x01 -> STATUS bit0 remains 1 and irq stays high.
REQ-035 SHALL cover: offset 9 read/write and bank 1 access with BANKS=1 -> bus_err=1, bus_data_out=0, no register change.
REQ-036 SHALL cover: rst_n low mid-operation with DIR=0xFF and STATUS=0x3 -> gpio_oe=0 and irq=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mgpio_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mgpio_ext_pkg
// Purpose  : Register offsets shared by the GPIO bank and its bus decoder.
// Revision : 1.0
// ============================================================================
package mgpio_ext_pkg;

  localparam int unsigned OFF_W = 4;

  localparam logic [OFF_W-1:0] OFF_DATA    = 4'd0;
  localparam logic [OFF_W-1:0] OFF_DIR     = 4'd1;
  localparam logic [OFF_W-1:0] OFF_IN      = 4'd2;
  localparam logic [OFF_W-1:0] OFF_SET     = 4'd3;
  localparam logic [OFF_W-1:0] OFF_CLR     = 4'd4;
  localparam logic [OFF_W-1:0] OFF_TGL     = 4'd5;
  localparam logic [OFF_W-1:0] OFF_RISE_EN = 4'd6;
  localparam logic [OFF_W-1:0] OFF_FALL_EN = 4'd7;
  localparam logic [OFF_W-1:0] OFF_STATUS  = 4'd8;
  localparam logic [OFF_W-1:0] OFF_LAST    = OFF_STATUS;

endpackage
`default_nettype wire

// File: rtl/mgpio_ext_bank.sv
`default_nettype none
// ============================================================================
// Module   : mgpio_ext_bank
// Purpose  : One GPIO bank: registers, input synchronizer, edge detect, STATUS.
// Revision : 1.0
// ============================================================================
module mgpio_ext_bank
  import mgpio_ext_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] dir_o,
  output logic [WIDTH-1:0] in_o,
  output logic [WIDTH-1:0] rise_en_o,
  output logic [WIDTH-1:0] fall_en_o,
  output logic [WIDTH-1:0] status_o,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] event_w;
  logic [WIDTH-1:0] w1c_w;

  always_comb begin
    sync_d[0] = pin_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign in_w    = sync_q[SYNC_STAGES-1];
  assign prev_d  = in_w;
  // Only sampled transitions count; enable changes alone never create events.
  assign event_w = (in_w & ~prev_q & rise_en_q) | (~in_w & prev_q & fall_en_q);

  always_comb begin
    data_d    = data_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_w     = '0;
    if (wr_en) begin
      case (wr_off)
        OFF_DATA:    data_d    = wr_data;
        OFF_DIR:     dir_d     = wr_data;
        OFF_SET:     data_d    = data_q | wr_data;
        OFF_CLR:     data_d    = data_q & ~wr_data;
        OFF_TGL:     data_d    = data_q ^ wr_data;
        OFF_RISE_EN: rise_en_d = wr_data;
        OFF_FALL_EN: fall_en_d = wr_data;
        OFF_STATUS:  w1c_w     = wr_data;
        default:     ;
      endcase
    end
    // A set event in the same cycle wins over the write-one-to-clear.
    status_d = (status_q & ~w1c_w) | event_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      data_q    <= data_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= prev_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign data_o    = data_q;
  assign dir_o     = dir_q;
  assign in_o      = in_w;
  assign rise_en_o = rise_en_q;
  assign fall_en_o = fall_en_q;
  assign status_o  = status_q;
  assign irq       = |status_q;

endmodule
`default_nettype wire

// File: rtl/mgpio_ext.sv
`default_nettype none
// ============================================================================
// Module   : mgpio_ext
// Purpose  : Multi-bank GPIO with bus decode, error flag and per-bank IRQs.
// Revision : 1.0
// ============================================================================
module mgpio_ext
  import mgpio_ext_pkg::*;
#(
  parameter int BANKS        = 1,
  parameter int WIDTH        = 8,
  parameter int BANK_AS_BITS = 12,
  parameter int SYNC_STAGES  = 2,
  localparam int BANKS_WIDTH = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BANK_AS_BITS+BANKS_WIDTH-1:0] bus_addr,
  input  logic [WIDTH-1:0]              bus_data_in,
  input  logic                          bus_write,
  output logic [WIDTH-1:0]              bus_data_out,
  output logic                          bus_err,
  input  logic [BANKS*WIDTH-1:0]        gpio_in,
  output logic [BANKS*WIDTH-1:0]        gpio_out,
  output logic [BANKS*WIDTH-1:0]        gpio_oe,
  output logic [BANKS-1:0]              irq_bank,
  output logic                          irq
);

  localparam int AW = BANK_AS_BITS + BANKS_WIDTH;

  logic [BANKS_WIDTH-1:0]  bank_w;
  logic [BANK_AS_BITS-1:0] off_w;
  logic                    off_bad_w;
  logic                    bank_bad_w;

  logic [WIDTH-1:0] data_w    [BANKS];
  logic [WIDTH-1:0] dir_w     [BANKS];
  logic [WIDTH-1:0] in_w      [BANKS];
  logic [WIDTH-1:0] rise_en_w [BANKS];
  logic [WIDTH-1:0] fall_en_w [BANKS];
  logic [WIDTH-1:0] status_w  [BANKS];

  assign bank_w     = bus_addr[AW-1:BANK_AS_BITS];
  assign off_w      = bus_addr[BANK_AS_BITS-1:0];
  assign off_bad_w  = off_w > BANK_AS_BITS'(OFF_LAST);
  assign bank_bad_w = {1'b0, bank_w} >= (BANKS_WIDTH+1)'(BANKS);
  assign bus_err    = off_bad_w | bank_bad_w;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic wr_en_w;
    assign wr_en_w = bus_write & ~bus_err & (bank_w == BANKS_WIDTH'(b));

    mgpio_ext_bank #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en_w),
      .wr_off    (off_w[OFF_W-1:0]),
      .wr_data   (bus_data_in),
      .pin_in    (gpio_in[b*WIDTH +: WIDTH]),
      .data_o    (data_w[b]),
      .dir_o     (dir_w[b]),
      .in_o      (in_w[b]),
      .rise_en_o (rise_en_w[b]),
      .fall_en_o (fall_en_w[b]),
      .status_o  (status_w[b]),
      .irq       (irq_bank[b])
    );

    assign gpio_out[b*WIDTH +: WIDTH] = data_w[b];
    assign gpio_oe[b*WIDTH +: WIDTH]  = dir_w[b];
  end

  always_comb begin
    bus_data_out = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (!bus_err && bank_w == BANKS_WIDTH'(b)) begin
        case (off_w[OFF_W-1:0])
          OFF_DATA:    bus_data_out = data_w[b];
          OFF_DIR:     bus_data_out = dir_w[b];
          OFF_IN:      bus_data_out = in_w[b];
          OFF_RISE_EN: bus_data_out = rise_en_w[b];
          OFF_FALL_EN: bus_data_out = fall_en_w[b];
          OFF_STATUS:  bus_data_out = status_w[b];
          default:     bus_data_out = '0;
        endcase
      end
    end
  end

  assign irq = |irq_bank;

endmodule
`default_nettype wire

// File: tb/tb_mgpio_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_mgpio_ext
// Purpose  : Directed bench for mgpio_ext in two- and one-bank configurations.
// Revision : 1.0
// ============================================================================
module tb_mgpio_ext;

  logic        clk;
  logic        rst_n;

  logic [12:0] a2;
  logic [7:0]  d2in;
  logic        w2;
  logic [7:0]  d2out;
  logic        e2;
  logic [15:0] gin2;
  logic [15:0] gout2;
  logic [15:0] goe2;
  logic [1:0]  irqb2;
  logic        irq2;

  logic [12:0] a1;
  logic [7:0]  d1in;
  logic        w1;
  logic [7:0]  d1out;
  logic        e1;
  logic [7:0]  gin1;
  logic [7:0]  gout1;
  logic [7:0]  goe1;
  logic [0:0]  irqb1;
  logic        irq1;

  int checks;
  int errors;

  mgpio_ext #(
    .BANKS(2), .WIDTH(8), .BANK_AS_BITS(12), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(a2), .bus_data_in(d2in), .bus_write(w2),
    .bus_data_out(d2out), .bus_err(e2),
    .gpio_in(gin2), .gpio_out(gout2), .gpio_oe(goe2),
    .irq_bank(irqb2), .irq(irq2)
  );

  mgpio_ext #(
    .BANKS(1), .WIDTH(8), .BANK_AS_BITS(12), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(a1), .bus_data_in(d1in), .bus_write(w1),
    .bus_data_out(d1out), .bus_err(e1),
    .gpio_in(gin1), .gpio_out(gout1), .gpio_oe(goe1),
    .irq_bank(irqb1), .irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr2(input logic bank, input logic [11:0] off, input logic [7:0] data);
    @(negedge clk);
    a2 = {bank, off}; d2in = data; w2 = 1'b1;
    @(negedge clk);
    w2 = 1'b0;
  endtask

  task automatic rd2(input logic bank, input logic [11:0] off, output logic [7:0] data);
    a2 = {bank, off};
    #1;
    data = d2out;
  endtask

  task automatic wr1(input logic bank, input logic [11:0] off, input logic [7:0] data);
    @(negedge clk);
    a1 = {bank, off}; d1in = data; w1 = 1'b1;
    @(negedge clk);
    w1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    #12;
    checks++;
    if (gout2 !== 16'h0000) begin errors++; $display("FAIL reset_gpio_out got %h exp 0000", gout2); end
    checks++;
    if (goe2 !== 16'h0000) begin errors++; $display("FAIL reset_gpio_oe got %h exp 0000", goe2); end
    checks++;
    if (irq2 !== 1'b0 || irqb2 !== 2'b00) begin errors++; $display("FAIL reset_irq got %b/%b exp 0/00", irq2, irqb2); end
    @(negedge clk);
    rst_n = 1'b1;
    rd2(1'b1, 12'd0, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", v); end
  endtask

  task automatic test_set_clr_tgl();
    logic [7:0] v;
    wr2(1'b1, 12'd0, 8'hA5);
    rd2(1'b1, 12'd0, v);
    checks++;
    if (v !== 8'hA5 || gout2[15:8] !== 8'hA5) begin errors++; $display("FAIL data_wr got %h/%h exp a5", v, gout2[15:8]); end
    wr2(1'b1, 12'd3, 8'h0F);
    rd2(1'b1, 12'd0, v);
    checks++;
    if (v !== 8'hAF || gout2[15:8] !== 8'hAF) begin errors++; $display("FAIL set got %h/%h exp af", v, gout2[15:8]); end
    wr2(1'b1, 12'd4, 8'h81);
    rd2(1'b1, 12'd0, v);
    checks++;
    if (v !== 8'h2E || gout2[15:8] !== 8'h2E) begin errors++; $display("FAIL clr got %h/%h exp 2e", v, gout2[15:8]); end
    wr2(1'b1, 12'd5, 8'hFF);
    rd2(1'b1, 12'd0, v);
    checks++;
    if (v !== 8'hD1 || gout2[15:8] !== 8'hD1) begin errors++; $display("FAIL tgl got %h/%h exp d1", v, gout2[15:8]); end
    checks++;
    if (gout2[7:0] !== 8'h00) begin errors++; $display("FAIL bank0_untouched got %h exp 00", gout2[7:0]); end
    rd2(1'b1, 12'd3, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL set_reads_zero got %h exp 00", v); end
    wr2(1'b1, 12'd1, 8'h3C);
    rd2(1'b1, 12'd1, v);
    checks++;
    if (v !== 8'h3C || goe2 !== 16'h3C00) begin errors++; $display("FAIL dir got %h/%h exp 3c/3c00", v, goe2); end
  endtask

  task automatic test_sync_edge();
    logic [7:0] v;
    wr2(1'b0, 12'd6, 8'h01);
    gin2[1:0] = 2'b11;
    @(posedge clk); #1;
    rd2(1'b0, 12'd2, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL in_n1 got %h exp 00", v); end
    @(posedge clk); #1;
    rd2(1'b0, 12'd2, v);
    checks++;
    if (v !== 8'h03) begin errors++; $display("FAIL in_n2 got %h exp 03", v); end
    rd2(1'b0, 12'd8, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL status_n2 got %h exp 00", v); end
    @(posedge clk); #1;
    rd2(1'b0, 12'd8, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL status_n3 got %h exp 01", v); end
    checks++;
    if (irq2 !== 1'b1 || irqb2 !== 2'b01) begin errors++; $display("FAIL irq_n3 got %b/%b exp 1/01", irq2, irqb2); end
  endtask

  task automatic test_w1c_priority();
    logic [7:0] v;
    wr2(1'b0, 12'd7, 8'h01);
    gin2[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    a2 = {1'b0, 12'd8}; d2in = 8'h01; w2 = 1'b1;
    @(negedge clk);
    w2 = 1'b0;
    rd2(1'b0, 12'd8, v);
    checks++;
    if (v !== 8'h01 || irq2 !== 1'b1) begin errors++; $display("FAIL w1c_priority got %h/%b exp 01/1", v, irq2); end
    wr2(1'b0, 12'd8, 8'h01);
    rd2(1'b0, 12'd8, v);
    checks++;
    if (v !== 8'h00 || irq2 !== 1'b0) begin errors++; $display("FAIL w1c_clear got %h/%b exp 00/0", v, irq2); end
    wr2(1'b0, 12'd6, 8'h03);
    repeat (3) @(negedge clk);
    rd2(1'b0, 12'd8, v);
    checks++;
    if (v !== 8'h00 || irq2 !== 1'b0) begin errors++; $display("FAIL enable_no_event got %h/%b exp 00/0", v, irq2); end
  endtask

  task automatic test_err();
    logic [7:0] v;
    wr1(1'b0, 12'd0, 8'h3C);
    a1 = {1'b0, 12'd9};
    #1;
    checks++;
    if (e1 !== 1'b1 || d1out !== 8'h00) begin errors++; $display("FAIL off9_read got err=%b data=%h exp 1/00", e1, d1out); end
    a1 = {1'b1, 12'd0};
    #1;
    checks++;
    if (e1 !== 1'b1 || d1out !== 8'h00) begin errors++; $display("FAIL bank1_read got err=%b data=%h exp 1/00", e1, d1out); end
    wr1(1'b0, 12'd9, 8'hFF);
    wr1(1'b1, 12'd0, 8'hFF);
    wr1(1'b1, 12'd1, 8'hFF);
    a1 = {1'b0, 12'd0};
    #1;
    checks++;
    if (e1 !== 1'b0 || d1out !== 8'h3C || gout1 !== 8'h3C || goe1 !== 8'h00) begin
      errors++; $display("FAIL err_no_change got err=%b data=%h out=%h oe=%h exp 0/3c/3c/00", e1, d1out, gout1, goe1);
    end
    a2 = {1'b1, 12'd9};
    #1;
    checks++;
    if (e2 !== 1'b1) begin errors++; $display("FAIL off9_dut2 got %b exp 1", e2); end
    a2 = {1'b1, 12'd8};
    #1;
    checks++;
    if (e2 !== 1'b0) begin errors++; $display("FAIL off8_ok got %b exp 0", e2); end
    @(negedge clk);
    a2 = {1'b1, 12'd2}; d2in = 8'hFF; w2 = 1'b1;
    #1;
    checks++;
    if (e2 !== 1'b0) begin errors++; $display("FAIL in_write_err got %b exp 0", e2); end
    @(negedge clk);
    w2 = 1'b0;
    rd2(1'b1, 12'd0, v);
    checks++;
    if (v !== 8'hD1) begin errors++; $display("FAIL in_write_no_effect got %h exp d1", v); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    wr2(1'b0, 12'd1, 8'hFF);
    gin2[1:0] = 2'b00;
    repeat (4) @(negedge clk);
    wr2(1'b0, 12'd8, 8'hFF);
    gin2[1:0] = 2'b11;
    repeat (4) @(negedge clk);
    rd2(1'b0, 12'd8, v);
    checks++;
    if (v !== 8'h03 || irq2 !== 1'b1 || goe2[7:0] !== 8'hFF) begin
      errors++; $display("FAIL pre_reset got status=%h irq=%b oe=%h exp 03/1/ff", v, irq2, goe2[7:0]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (goe2 !== 16'h0000 || irq2 !== 1'b0 || irqb2 !== 2'b00 || gout2 !== 16'h0000) begin
      errors++; $display("FAIL async_reset got oe=%h irq=%b out=%h exp 0000/0/0000", goe2, irq2, gout2);
    end
    gin2 = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd2(1'b0, 12'd8, v);
    checks++;
    if (v !== 8'h00 || irq2 !== 1'b0) begin errors++; $display("FAIL release_no_event got %h/%b exp 00/0", v, irq2); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a2 = '0; d2in = '0; w2 = 1'b0; gin2 = '0;
    a1 = '0; d1in = '0; w1 = 1'b0; gin1 = '0;
    test_reset();
    test_set_clr_tgl();
    test_sync_edge();
    test_w1c_priority();
    test_err();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
